reg_bus_decoder_tmo: RTL
========================

Name: reg_bus_decoder_tmo

Overview:
Parametrised register-bus demultiplexer that replaces the fixed peripheral decode with a rule-driven N-slave decoder. It registers each request, routes it to the slave whose address window matches, and returns that slave's response. Unmapped addresses get an error response, and slaves that never answer are cut off by a per-transaction timeout. It sits between the AXI-to-reg bridge and the peripheral register slaves (SoC ctrl, bootrom, interrupt ctrl, UART, external).

Parameters:
NumSlaves, 5, number of slave ports and address rules (>=1)
AddrWidth, 64, address width
DataWidth, 32, data width; strobe width is DataWidth/8
TimeoutCycles, 256, cycles a slave may stall before an error is forced (>=2)
CntWidth, 16, width of the saturating error counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous active-high
rule_start_i  in  NumSlaves*AddrWidth  window start per slave, inclusive; slice i belongs to slave i
rule_end_i  in  NumSlaves*AddrWidth  window end per slave, exclusive
mst_valid_i  in  1  master request valid
mst_write_i  in  1  1=write, 0=read
mst_addr_i  in  AddrWidth  request address
mst_wdata_i  in  DataWidth  write data
mst_wstrb_i  in  DataWidth/8  write strobes
mst_ready_o  out  1  one-cycle completion pulse to master
mst_rdata_o  out  DataWidth  read data, valid with mst_ready_o
mst_error_o  out  1  error flag, valid with mst_ready_o
slv_valid_o  out  NumSlaves  one-hot request valid
slv_write_o  out  1  broadcast write flag
slv_addr_o  out  AddrWidth  broadcast address
slv_wdata_o  out  DataWidth  broadcast write data
slv_wstrb_o  out  DataWidth/8  broadcast strobes
slv_ready_i  in  NumSlaves  per-slave ready
slv_rdata_i  in  NumSlaves*DataWidth  per-slave read data
slv_error_i  in  NumSlaves  per-slave error
tmo_clr_i  in  1  clears tmo_sticky_o
tmo_sticky_o  out  1  set on any timeout
err_count_o  out  CntWidth  saturating count of error responses returned to master

Behaviour:
- Reset (at the clock edge with rst_i=1): FSM=IDLE; all outputs 0; err_count_o=0; tmo_sticky_o=0; timeout counter=0.
- Address decode: slave i matches when rule_start_i[i] <= addr < rule_end_i[i] (unsigned compare). If several rules match, the lowest index wins. A rule with start >= end never matches.
- States: IDLE, FWD, RESP.
- IDLE, with mst_valid_i=1: latch write/addr/wdata/wstrb and the decode result.
  - Match to slave k -> FWD.
  - No match -> RESP with error=1 and rdata=0.
- FWD: slv_valid_o = onehot(k); broadcast fields come from the latch; the timeout counter increments each cycle.
  - slv_ready_i[k]=1 -> capture slv_rdata_i[k] and slv_error_i[k], drop slv_valid_o on the next edge, go to RESP.
  - Counter reaches TimeoutCycles-1 with no ready -> drop slv_valid_o, go to RESP with error=1 and rdata=0, set tmo_sticky_o.
  - Ready arriving in the same cycle as the timeout takes priority: the slave's response is used and there is no timeout.
  - slv_ready_i on non-selected slaves is ignored.
- RESP: mst_ready_o=1 for exactly one cycle, with mst_rdata_o and mst_error_o from the capture; counter cleared; next state IDLE. The master may start a new request the cycle after mst_ready_o.
- Latency: request seen in cycle 0; slv_valid_o high in cycle 1. A slave ready in cycle r gives mst_ready_o in cycle r+1. A decode error gives mst_ready_o in cycle 1.
- mst_rdata_o and mst_error_o are 0 whenever mst_ready_o=0.
- Throughput: at most one outstanding transaction. mst_valid_i seen during FWD or RESP is not sampled.
- Master dropping valid mid-transaction: the transaction still completes and mst_ready_o still pulses.
- err_count_o increments on each RESP with error=1 (decode, timeout or slave error) and saturates at all-ones.
- tmo_sticky_o: set has priority over tmo_clr_i in the same cycle.
- Reset mid-transaction: slv_valid_o and mst_ready_o are 0 after the edge; the transaction is lost with no response.
- rule_*_i are sampled only in IDLE and must be quasi-static.

Test Plan:
- Rules {0x0-0x1000, 0x10000-0x20000, ...}; read 0x10 from slave 0, which answers ready in its first valid cycle with rdata 0xA5A5_0001 -> slv_valid_o=5'b00001 in cycle 1, mst_ready_o in cycle 2 with rdata 0xA5A5_0001 and error 0.
- Write 0x30008, wdata 0x55, wstrb 0x1 -> only slv_valid_o[3] asserted; slv_wdata_o/slv_wstrb_o match; slave ready after 5 cycles -> mst_ready_o exactly one cycle later.
- Read unmapped 0x5000_0000 -> mst_ready_o in cycle 1, error 1, rdata 0, err_count_o=1, no slv_valid_o asserted.
- Slave 2 never ready, TimeoutCycles=8 -> slv_valid_o[2] high 8 cycles then low; mst_ready_o with error 1; tmo_sticky_o=1 until tmo_clr_i pulses.
- Overlapping rules 1 and 2 on address 0x20000 -> slave 1 selected. Slave ready in the same cycle as the timeout -> slave data returned and tmo_sticky_o stays 0.
- rst_i asserted in FWD -> all outputs 0 next cycle. Force err_count_o to 0xFFFF plus one more error -> stays 0xFFFF.

Source files
------------

// File: rtl/reg_bus_decoder_tmo.sv
// Rule-driven register-bus demultiplexer: registers one request at a time, routes it
// to the first slave whose [start, end) window matches, and bounds slave stalls with a timeout.
module reg_bus_decoder_tmo #(
  parameter int unsigned NumSlaves     = 5,
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumSlaves*AddrWidth-1:0] rule_start_i,
  input  logic [NumSlaves*AddrWidth-1:0] rule_end_i,
  input  logic                           mst_valid_i,
  input  logic                           mst_write_i,
  input  logic [AddrWidth-1:0]           mst_addr_i,
  input  logic [DataWidth-1:0]           mst_wdata_i,
  input  logic [DataWidth/8-1:0]         mst_wstrb_i,
  output logic                           mst_ready_o,
  output logic [DataWidth-1:0]           mst_rdata_o,
  output logic                           mst_error_o,
  output logic [NumSlaves-1:0]           slv_valid_o,
  output logic                           slv_write_o,
  output logic [AddrWidth-1:0]           slv_addr_o,
  output logic [DataWidth-1:0]           slv_wdata_o,
  output logic [DataWidth/8-1:0]         slv_wstrb_o,
  input  logic [NumSlaves-1:0]           slv_ready_i,
  input  logic [NumSlaves*DataWidth-1:0] slv_rdata_i,
  input  logic [NumSlaves-1:0]           slv_error_i,
  input  logic                           tmo_clr_i,
  output logic                           tmo_sticky_o,
  output logic [CntWidth-1:0]            err_count_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned TmoWidth  = $clog2(TimeoutCycles);
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFwd  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] wstrb_q, wstrb_d;
  logic [NumSlaves-1:0] sel_q, sel_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic [TmoWidth-1:0]  cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;

  logic [NumSlaves-1:0] dec_hit;
  logic                 dec_found;
  logic                 sel_ready;
  logic                 sel_error;
  logic [DataWidth-1:0] sel_rdata;
  logic                 resp_err;
  logic                 tmo_set;

  // Lowest-index matching window wins; an empty or inverted window never matches.
  always_comb begin
    dec_hit   = '0;
    dec_found = 1'b0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (!dec_found &&
          rule_start_i[i*AddrWidth +: AddrWidth] < rule_end_i[i*AddrWidth +: AddrWidth] &&
          rule_start_i[i*AddrWidth +: AddrWidth] <= mst_addr_i &&
          mst_addr_i < rule_end_i[i*AddrWidth +: AddrWidth]) begin
        dec_hit[i] = 1'b1;
        dec_found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | slv_rdata_i[i*DataWidth +: DataWidth];
    end
    sel_ready = |(slv_ready_i & sel_q);
    sel_error = |(slv_error_i & sel_q);
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    error_d  = error_q;
    cnt_d    = cnt_q;
    resp_err = 1'b0;
    tmo_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (mst_valid_i) begin
          write_d = mst_write_i;
          addr_d  = mst_addr_i;
          wdata_d = mst_wdata_i;
          wstrb_d = mst_wstrb_i;
          sel_d   = dec_hit;
          cnt_d   = '0;
          if (dec_found) begin
            state_d = StFwd;
          end else begin
            state_d  = StResp;
            rdata_d  = '0;
            error_d  = 1'b1;
            resp_err = 1'b1;
          end
        end
      end
      StFwd: begin
        // A ready in the final timeout cycle still wins over the timeout.
        if (sel_ready) begin
          state_d  = StResp;
          rdata_d  = sel_rdata;
          error_d  = sel_error;
          resp_err = sel_error;
          cnt_d    = '0;
        end else if (cnt_q == TmoLast) begin
          state_d  = StResp;
          rdata_d  = '0;
          error_d  = 1'b1;
          resp_err = 1'b1;
          tmo_set  = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + TmoWidth'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (resp_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + CntWidth'(1);
    tmo_d = tmo_q;
    if (tmo_set) tmo_d = 1'b1;
    else if (tmo_clr_i) tmo_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign slv_valid_o  = (state_q == StFwd) ? sel_q : '0;
  assign slv_write_o  = write_q;
  assign slv_addr_o   = addr_q;
  assign slv_wdata_o  = wdata_q;
  assign slv_wstrb_o  = wstrb_q;
  assign mst_ready_o  = (state_q == StResp);
  assign mst_rdata_o  = mst_ready_o ? rdata_q : '0;
  assign mst_error_o  = mst_ready_o ? error_q : 1'b0;
  assign tmo_sticky_o = tmo_q;
  assign err_count_o  = err_cnt_q;

endmodule
